// File: rtl/direct_mapped_cache.sv
// Read-only direct-mapped cache in front of MainMemory.
// Each line holds four 32-bit words. Hits complete in two cycles.
// A miss fetches the whole 128-bit block and overwrites the indexed line.
// Hit and access counters saturate at all-ones.
module direct_mapped_cache #(
    parameter int INDEX_BITS = 10,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [14:0]          cpu_address,
    input  logic                 cpu_read,
    output logic [31:0]          cpu_data,
    output logic                 cpu_ready,
    output logic                 hit,
    output logic [14:0]          mem_address,
    output logic                 mem_read,
    input  logic                 mem_data_ready,
    input  logic [127:0]         mem_data_block,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] access_count
);

    localparam int TAG_BITS = 13 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        MEM_REQ,
        MEM_WAIT,
        FILL
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Line storage. Valid bits live in flops so reset can clear them all at once;
    // tags and data sit in arrays that map onto block RAM.
    logic [LINES-1:0]    valid_reg;
    logic [TAG_BITS-1:0] tag_mem [LINES];
    logic [127:0]        data_mem [LINES];

    logic [TAG_BITS-1:0] tag_rd_reg;
    logic [127:0]        data_rd_reg;

    logic [14:0]          req_addr_reg;
    logic [31:0]          fill_word_reg;
    logic                 ready_sync1_reg;
    logic                 ready_sync2_reg;

    logic [31:0]          cpu_data_reg;
    logic                 cpu_ready_reg;
    logic                 hit_reg;
    logic [14:0]          mem_address_reg;
    logic                 mem_read_reg;
    logic [CNT_WIDTH-1:0] hit_count_reg;
    logic [CNT_WIDTH-1:0] access_count_reg;

    logic [INDEX_BITS-1:0] cpu_idx;
    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [1:0]            req_word;
    logic                  lookup_hit;
    logic                  fill_en;

    logic [31:0] line_words  [4];
    logic [31:0] block_words [4];

    assign cpu_idx  = cpu_address[INDEX_BITS+1:2];
    assign req_idx  = req_addr_reg[INDEX_BITS+1:2];
    assign req_tag  = req_addr_reg[14:INDEX_BITS+2];
    assign req_word = req_addr_reg[1:0];

    // Split the stored line and the incoming block into their four words.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_words
            assign line_words[gi]  = data_rd_reg[32*gi +: 32];
            assign block_words[gi] = mem_data_block[32*gi +: 32];
        end
    endgenerate

    // The read registers were loaded on the acceptance edge, so in COMPARE
    // they hold exactly the line that req_addr_reg indexes.
    assign lookup_hit = valid_reg[req_idx] && (tag_rd_reg == req_tag);
    assign fill_en    = (state_reg == MEM_WAIT) && ready_sync2_reg;

    // Registered read of the tag and data arrays at the presented address.
    always_ff @(posedge clk) begin
        tag_rd_reg  <= tag_mem[cpu_idx];
        data_rd_reg <= data_mem[cpu_idx];
    end

    // Allocate the fetched block into the indexed line.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[req_idx]  <= req_tag;
            data_mem[req_idx] <= mem_data_block;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (cpu_read) state_next = COMPARE;
            COMPARE:  state_next = lookup_hit ? IDLE : MEM_REQ;
            MEM_REQ:  state_next = MEM_WAIT;
            MEM_WAIT: if (ready_sync2_reg) state_next = FILL;
            FILL:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Bring dataReady into the clock domain. The pipe is flushed while the
    // request is issued so a dataReady left over from the previous miss
    // cannot be mistaken for the new block.
    always_ff @(posedge clk) begin
        if (!rst || state_reg == COMPARE) begin
            ready_sync1_reg <= 1'b0;
            ready_sync2_reg <= 1'b0;
        end else begin
            ready_sync1_reg <= mem_data_ready;
            ready_sync2_reg <= ready_sync1_reg;
        end
    end

    // Request latch, valid bits and the word captured for the fill response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_addr_reg  <= '0;
            valid_reg     <= '0;
            fill_word_reg <= '0;
        end else begin
            if (state_reg == IDLE && cpu_read) begin
                req_addr_reg <= cpu_address;
            end
            if (fill_en) begin
                valid_reg[req_idx] <= 1'b1;
                fill_word_reg      <= block_words[req_word];
            end
        end
    end

    // MainMemory request: raised on a miss, dropped when the block arrives.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_address_reg <= '0;
            mem_read_reg    <= 1'b0;
        end else if (state_reg == COMPARE && !lookup_hit) begin
            mem_address_reg <= {req_addr_reg[14:2], 2'b00};
            mem_read_reg    <= 1'b1;
        end else if (fill_en) begin
            mem_read_reg    <= 1'b0;
        end
    end

    // CPU response: one-cycle ready pulse; data and hit hold until the next one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cpu_data_reg  <= '0;
            cpu_ready_reg <= 1'b0;
            hit_reg       <= 1'b0;
        end else begin
            cpu_ready_reg <= 1'b0;
            if (state_reg == COMPARE && lookup_hit) begin
                cpu_data_reg  <= line_words[req_word];
                cpu_ready_reg <= 1'b1;
                hit_reg       <= 1'b1;
            end else if (state_reg == FILL) begin
                cpu_data_reg  <= fill_word_reg;
                cpu_ready_reg <= 1'b1;
                hit_reg       <= 1'b0;
            end
        end
    end

    // Saturating hit and access counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_count_reg    <= '0;
            access_count_reg <= '0;
        end else begin
            if (state_reg == COMPARE && lookup_hit) begin
                if (hit_count_reg != '1) begin
                    hit_count_reg <= hit_count_reg + 1'b1;
                end
                if (access_count_reg != '1) begin
                    access_count_reg <= access_count_reg + 1'b1;
                end
            end else if (state_reg == FILL) begin
                if (access_count_reg != '1) begin
                    access_count_reg <= access_count_reg + 1'b1;
                end
            end
        end
    end

    assign cpu_data     = cpu_data_reg;
    assign cpu_ready    = cpu_ready_reg;
    assign hit          = hit_reg;
    assign mem_address  = mem_address_reg;
    assign mem_read     = mem_read_reg;
    assign hit_count    = hit_count_reg;
    assign access_count = access_count_reg;

endmodule
